// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - multi-cycle data-memory responder for the CPU load/store handshake
//
// Purpose:
//   Services READ/WRITE strobes from the CPU control unit. A request is
//   latched in IDLE and the CPU is stalled with BUSYWAIT for LATENCY+1 edges.
//   After the access completes, the block spends one DONE cycle with BUSYWAIT
//   low so the CPU can drop its strobes before the next request is sampled.
//
// Ports:
//   CLK        in   rising-edge clock
//   RESET_N    in   asynchronous active-low reset
//   READ       in   read request, held until BUSYWAIT falls
//   WRITE      in   write request, held until BUSYWAIT falls
//   ADDRESS    in   word address (ADDR_WIDTH)
//   WRITEDATA  in   store data (DATA_WIDTH)
//   READDATA   out  registered load result (DATA_WIDTH)
//   CONFLICT   out  only with DMEM_CONFLICT_EN: pulses in DONE of a dropped READ+WRITE request
//   BUSYWAIT   out  CPU stall
//
// Build option:
//   DMEM_CONFLICT_EN - when defined, simultaneous READ and WRITE is dropped
//   and flagged on CONFLICT; otherwise it is serviced as a read.

module data_memory_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LATENCY    = 5
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [DATA_WIDTH-1:0] WRITEDATA,
  output logic [DATA_WIDTH-1:0] READDATA,
`ifdef DMEM_CONFLICT_EN
  output logic                  CONFLICT,
`endif
  output logic                  BUSYWAIT
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    op_wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    mem_we;
`ifdef DMEM_CONFLICT_EN
  logic                    conflict_q;
`endif

  // Stall is combinational in IDLE so the CPU freezes in the same cycle
  // it raises a strobe; DONE deliberately releases the CPU for one cycle.
  assign BUSYWAIT = (state_q == S_BUSY) || ((state_q == S_IDLE) && (READ || WRITE));

  // A conflicting request latches op_wr_q = 0, so it can never write.
  // A reset mid-access forces state_q to IDLE at once, which kills the write.
  assign mem_we = (state_q == S_BUSY) && (cnt_q == 4'd0) && op_wr_q;

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      READDATA   <= '0;
`ifdef DMEM_CONFLICT_EN
      conflict_q <= 1'b0;
      CONFLICT   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (READ || WRITE) begin
            // READ wins when both strobes are high.
            op_wr_q <= WRITE && !READ;
            addr_q  <= ADDRESS;
            wdata_q <= WRITEDATA;
            cnt_q   <= CNT_INIT;
            state_q <= S_BUSY;
`ifdef DMEM_CONFLICT_EN
            conflict_q <= READ && WRITE;
`endif
          end
        end
        S_BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
`ifdef DMEM_CONFLICT_EN
            if (!op_wr_q && !conflict_q) begin
              READDATA <= mem_q[addr_q];
            end
            CONFLICT <= conflict_q;
`else
            if (!op_wr_q) begin
              READDATA <= mem_q[addr_q];
            end
`endif
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
`ifdef DMEM_CONFLICT_EN
          CONFLICT <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - directed self-checking bench for data_memory_responder

module tb_data_memory_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd = 1'b0, wr = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00;
  logic [7:0] rdata;
  logic       busy;
  logic       conflict;

  logic       b_rd = 1'b0, b_wr = 1'b0;
  logic [7:0] b_addr = 8'h00, b_wdata = 8'h00;
  logic [7:0] b_rdata;
  logic       b_busy;
  logic       b_conflict;

  int errors = 0;
  int checks = 0;
  int edges;

  always #5 clk = ~clk;

  data_memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(5)) dut (
    .CLK(clk), .RESET_N(rst_n), .READ(rd), .WRITE(wr),
    .ADDRESS(addr), .WRITEDATA(wdata), .READDATA(rdata),
`ifdef DMEM_CONFLICT_EN
    .CONFLICT(conflict),
`endif
    .BUSYWAIT(busy)
  );

  data_memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(1)) dut_lat1 (
    .CLK(clk), .RESET_N(rst_n), .READ(b_rd), .WRITE(b_wr),
    .ADDRESS(b_addr), .WRITEDATA(b_wdata), .READDATA(b_rdata),
`ifdef DMEM_CONFLICT_EN
    .CONFLICT(b_conflict),
`endif
    .BUSYWAIT(b_busy)
  );

`ifndef DMEM_CONFLICT_EN
  assign conflict   = 1'b0;
  assign b_conflict = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with strobes already driven; counts rising edges
  // until BUSYWAIT is seen low, and returns at the negedge in DONE.
  task automatic wait_release(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!busy) break;
    end
  endtask

  task automatic access(input logic r, input logic w, input logic [7:0] a,
                        input logic [7:0] d, output int n);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    #1;
    check("busy_immediate", busy, 1);
    wait_release(n);
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic access_b(input logic r, input logic w, input logic [7:0] a,
                          input logic [7:0] d, output int n);
    @(negedge clk);
    b_rd = r; b_wr = w; b_addr = a; b_wdata = d;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!b_busy) break;
    end
    b_rd = 1'b0; b_wr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #2;
    check("reset_busy", busy, 0);
    check("reset_rdata", rdata, 0);
    check("reset_conflict", conflict, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Write then read back
    access(1'b0, 1'b1, 8'h10, 8'hA5, edges);
    check("wr10_edges", edges, 6);
    check("wr10_rdata_held", rdata, 0);
    access(1'b1, 1'b0, 8'h10, 8'h00, edges);
    check("rd10_edges", edges, 6);
    check("rd10_data", rdata, 8'hA5);

    // Address change during BUSY is ignored
    access(1'b0, 1'b1, 8'h20, 8'h3C, edges);
    access(1'b0, 1'b1, 8'h21, 8'h77, edges);
    @(negedge clk);
    rd = 1'b1; addr = 8'h20;
    @(posedge clk);
    @(negedge clk);
    addr = 8'h21;
    wait_release(edges);
    check("rd20_edges", edges, 5);
    check("rd20_latched_addr", rdata, 8'h3C);
    rd = 1'b0;
    @(negedge clk);

    // Reset in the middle of a write aborts it
    access(1'b0, 1'b1, 8'h05, 8'h11, edges);
    @(negedge clk);
    wr = 1'b1; addr = 8'h05; wdata = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; wr = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_rdata", rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b1, 1'b0, 8'h05, 8'h00, edges);
    check("rd05_after_abort", rdata, 8'h11);

    // READ held through two accesses: one-cycle DONE gap
    access(1'b0, 1'b1, 8'h00, 8'h5A, edges);
    access(1'b0, 1'b1, 8'h01, 8'hC3, edges);
    @(negedge clk);
    rd = 1'b1; addr = 8'h00;
    wait_release(edges);
    check("held_first_edges", edges, 6);
    check("held_first_data", rdata, 8'h5A);
    addr = 8'h01;
    @(negedge clk);
    check("held_gap_rise", busy, 1);
    wait_release(edges);
    check("held_second_edges", edges, 6);
    check("held_second_data", rdata, 8'hC3);
    rd = 1'b0;
    @(negedge clk);

    // Simultaneous READ and WRITE
    access(1'b0, 1'b1, 8'h40, 8'h12, edges);
    @(negedge clk);
    rd = 1'b1; wr = 1'b1; addr = 8'h40; wdata = 8'h99;
    wait_release(edges);
    check("both_edges", edges, 6);
`ifdef DMEM_CONFLICT_EN
    check("both_rdata_unchanged", rdata, 8'hC3);
    check("both_conflict_pulse", conflict, 1);
`else
    check("both_read_data", rdata, 8'h12);
    check("both_no_conflict", conflict, 0);
`endif
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    check("conflict_cleared", conflict, 0);
    access(1'b1, 1'b0, 8'h40, 8'h00, edges);
    check("rd40_unchanged", rdata, 8'h12);

    // LATENCY=1 instance
    access_b(1'b0, 1'b1, 8'h07, 8'hE1, edges);
    check("lat1_wr_edges", edges, 2);
    access_b(1'b1, 1'b0, 8'h07, 8'h00, edges);
    check("lat1_rd_edges", edges, 2);
    check("lat1_rd_data", b_rdata, 8'hE1);
    access_b(1'b0, 1'b1, 8'hFF, 8'h3D, edges);
    access_b(1'b1, 1'b0, 8'hFF, 8'h00, edges);
    check("lat1_top_addr", b_rdata, 8'h3D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
